// File: rtl/bf_pkg.sv
// Shared definitions for the Brainfuck decode slice: micro-op codes, opcode
// classes and the ASCII command bytes.
package bf_pkg;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_MOVE = 3'd1;
   localparam logic [2:0] OP_JZ   = 3'd2;
   localparam logic [2:0] OP_JNZ  = 3'd3;
   localparam logic [2:0] OP_OUT  = 3'd4;
   localparam logic [2:0] OP_IN   = 3'd5;
   localparam logic [2:0] OP_HALT = 3'd7;

   typedef enum logic [1:0] {
      CLS_NOP  = 2'd0,
      CLS_ADD  = 2'd1,
      CLS_MOVE = 2'd2,
      CLS_CTRL = 2'd3
   } op_class_t;

   localparam logic [7:0] CH_PLUS  = 8'h2B;
   localparam logic [7:0] CH_MINUS = 8'h2D;
   localparam logic [7:0] CH_GT    = 8'h3E;
   localparam logic [7:0] CH_LT    = 8'h3C;
   localparam logic [7:0] CH_LBR   = 8'h5B;
   localparam logic [7:0] CH_RBR   = 8'h5D;
   localparam logic [7:0] CH_DOT   = 8'h2E;
   localparam logic [7:0] CH_COMMA = 8'h2C;
   localparam logic [7:0] CH_HALT  = 8'h00;

endpackage

// File: rtl/bf_opcode_class.sv
// Combinational classifier: maps a fetched byte to its class, fold step and
// micro-op code.
module bf_opcode_class
   import bf_pkg::*;
#(
   parameter int D_WIDTH = 8
) (
   input  logic [D_WIDTH-1:0] opcode,
   output op_class_t          cls,
   output logic signed [1:0]  step,
   output logic [2:0]         op_code
);

   always_comb begin
      cls     = CLS_NOP;
      step    = 2'sd0;
      op_code = OP_ADD;
      case (opcode)
         D_WIDTH'(CH_PLUS): begin
            cls     = CLS_ADD;
            step    = 2'sd1;
            op_code = OP_ADD;
         end
         D_WIDTH'(CH_MINUS): begin
            cls     = CLS_ADD;
            step    = -2'sd1;
            op_code = OP_ADD;
         end
         D_WIDTH'(CH_GT): begin
            cls     = CLS_MOVE;
            step    = 2'sd1;
            op_code = OP_MOVE;
         end
         D_WIDTH'(CH_LT): begin
            cls     = CLS_MOVE;
            step    = -2'sd1;
            op_code = OP_MOVE;
         end
         D_WIDTH'(CH_LBR): begin
            cls     = CLS_CTRL;
            op_code = OP_JZ;
         end
         D_WIDTH'(CH_RBR): begin
            cls     = CLS_CTRL;
            op_code = OP_JNZ;
         end
         D_WIDTH'(CH_DOT): begin
            cls     = CLS_CTRL;
            op_code = OP_OUT;
         end
         D_WIDTH'(CH_COMMA): begin
            cls     = CLS_CTRL;
            op_code = OP_IN;
         end
         D_WIDTH'(CH_HALT): begin
            cls     = CLS_CTRL;
            op_code = OP_HALT;
         end
         default: begin
            cls     = CLS_NOP;
            step    = 2'sd0;
            op_code = OP_ADD;
         end
      endcase
   end

endmodule

// File: rtl/stage_decode.sv
// Decode stage: folds +/- and </> runs into single ADD/MOVE micro-ops, passes
// control opcodes straight through, and stops accepting after HALT.
module stage_decode
   import bf_pkg::*;
#(
   parameter int A_WIDTH = 12,
   parameter int D_WIDTH = 8,
   parameter int MAX_RUN = 255
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [D_WIDTH-1:0] opcode,
   input  logic               in_valid,
   output logic               ack_out,
   output logic [2:0]         op,
   output logic [A_WIDTH-1:0] operand,
   output logic               op_valid,
   input  logic               ack_in
);

   localparam logic [1:0] ACC_EMPTY = 2'd0;
   localparam logic [1:0] ACC_ADD   = 2'd1;
   localparam logic [1:0] ACC_MOVE  = 2'd2;

   op_class_t                 in_cls;
   logic signed [1:0]         in_step;
   logic [2:0]                in_op;

   logic [1:0]                acc_cls_p0;
   logic signed [A_WIDTH-1:0] acc_delta_p0;
   logic [7:0]                acc_cnt_p0;
   logic                      halted_p0;

   logic [2:0]                op_p1;
   logic [A_WIDTH-1:0]        operand_p1;
   logic                      vld_p1;

   logic [1:0]                in_acc_cls;
   logic signed [A_WIDTH-1:0] step_ext;
   logic                      slot_free;
   logic                      acc_empty;
   logic                      run_open;
   logic [A_WIDTH-1:0]        flush_operand;
   logic [2:0]                flush_op;
   logic                      flush_emits;
   logic                      want_load, want_fold, want_flush, want_ctrl;
   logic                      do_load, do_fold, do_flush, do_ctrl;

   // ADD wraps at the cell width; MOVE keeps the full pointer-width delta.
   function automatic logic [A_WIDTH-1:0] fold_operand(
      input logic [1:0]                cls,
      input logic signed [A_WIDTH-1:0] delta
   );
      if (cls == ACC_MOVE) return $unsigned(delta);
      return {{(A_WIDTH-D_WIDTH){1'b0}}, delta[D_WIDTH-1:0]};
   endfunction

   bf_opcode_class #(
      .D_WIDTH (D_WIDTH)
   ) u_class (
      .opcode  (opcode),
      .cls     (in_cls),
      .step    (in_step),
      .op_code (in_op)
   );

   always_comb begin
      case (in_cls)
         CLS_ADD:  in_acc_cls = ACC_ADD;
         CLS_MOVE: in_acc_cls = ACC_MOVE;
         default:  in_acc_cls = ACC_EMPTY;
      endcase
   end

   assign step_ext      = {{(A_WIDTH-1){in_step[1]}}, in_step[0]};
   assign slot_free     = !vld_p1 || ack_in;
   assign acc_empty     = (acc_cls_p0 == ACC_EMPTY);
   assign run_open      = (in_acc_cls == acc_cls_p0) && (acc_cnt_p0 < 8'(MAX_RUN));
   assign flush_operand = fold_operand(acc_cls_p0, acc_delta_p0);
   assign flush_op      = (acc_cls_p0 == ACC_MOVE) ? OP_MOVE : OP_ADD;
   assign flush_emits   = (flush_operand != '0);

   // A control op behind a pending run stalls fetch while the run is flushed.
   always_comb begin
      ack_out    = 1'b0;
      want_load  = 1'b0;
      want_fold  = 1'b0;
      want_flush = 1'b0;
      want_ctrl  = 1'b0;
      if (reset && !halted_p0) begin
         case (in_cls)
            CLS_NOP: ack_out = 1'b1;
            CLS_ADD, CLS_MOVE: begin
               if (acc_empty) begin
                  ack_out   = 1'b1;
                  want_load = 1'b1;
               end else if (run_open) begin
                  ack_out   = 1'b1;
                  want_fold = 1'b1;
               end else if (slot_free) begin
                  ack_out    = 1'b1;
                  want_flush = 1'b1;
                  want_load  = 1'b1;
               end
            end
            CLS_CTRL: begin
               if (!acc_empty) begin
                  want_flush = slot_free;
               end else if (slot_free) begin
                  ack_out   = 1'b1;
                  want_ctrl = 1'b1;
               end
            end
            default: ack_out = 1'b0;
         endcase
      end
   end

   assign do_load  = in_valid && want_load;
   assign do_fold  = in_valid && want_fold;
   assign do_flush = in_valid && want_flush;
   assign do_ctrl  = in_valid && want_ctrl;

   // p0: run accumulator and halt flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_cls_p0   <= ACC_EMPTY;
         acc_delta_p0 <= '0;
         acc_cnt_p0   <= 8'd0;
         halted_p0    <= 1'b0;
      end else begin
         if (do_load) begin
            acc_cls_p0   <= in_acc_cls;
            acc_delta_p0 <= step_ext;
            acc_cnt_p0   <= 8'd1;
         end else if (do_fold) begin
            acc_delta_p0 <= acc_delta_p0 + step_ext;
            acc_cnt_p0   <= acc_cnt_p0 + 8'd1;
         end else if (do_flush) begin
            acc_cls_p0   <= ACC_EMPTY;
            acc_delta_p0 <= '0;
            acc_cnt_p0   <= 8'd0;
         end
         if (do_ctrl && (in_op == OP_HALT)) halted_p0 <= 1'b1;
      end
   end

   // p1: output slot toward execute
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_p1      <= OP_ADD;
         operand_p1 <= '0;
         vld_p1     <= 1'b0;
      end else if (do_ctrl) begin
         op_p1      <= in_op;
         operand_p1 <= '0;
         vld_p1     <= 1'b1;
      end else if (do_flush && flush_emits) begin
         op_p1      <= flush_op;
         operand_p1 <= flush_operand;
         vld_p1     <= 1'b1;
      end else if (ack_in) begin
         vld_p1     <= 1'b0;
      end
   end

   assign op       = op_p1;
   assign operand  = operand_p1;
   assign op_valid = vld_p1;

endmodule

// File: tb/tb_stage_decode.sv
// Bench for stage_decode: directed scenarios plus random opcode streams
// checked against a run-folding reference model.
module tb_stage_decode;

   localparam int A_WIDTH = 12;
   localparam int D_WIDTH = 8;
   localparam int MAX_RUN = 255;

   localparam logic [2:0] T_ADD  = 3'd0;
   localparam logic [2:0] T_MOVE = 3'd1;
   localparam logic [2:0] T_JZ   = 3'd2;
   localparam logic [2:0] T_JNZ  = 3'd3;
   localparam logic [2:0] T_OUT  = 3'd4;
   localparam logic [2:0] T_IN   = 3'd5;
   localparam logic [2:0] T_HALT = 3'd7;

   typedef logic [14:0] mop_t;
   typedef mop_t        mop_q_t[$];
   typedef logic [7:0]  byte_q_t[$];

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  opcode = 8'h00;
   logic        in_valid = 1'b0;
   logic        ack_out;
   logic [2:0]  op;
   logic [11:0] operand;
   logic        op_valid;
   logic        ack_in = 1'b0;

   int          errors = 0;
   int          checks = 0;
   int          ack_mode = 0;
   mop_q_t      obs_q;
   mop_q_t      exp_q;
   byte_q_t     sent_q;
   logic        prev_hold = 1'b0;
   logic [2:0]  prev_op = 3'd0;
   logic [11:0] prev_operand = 12'd0;

   stage_decode #(
      .A_WIDTH (A_WIDTH),
      .D_WIDTH (D_WIDTH),
      .MAX_RUN (MAX_RUN)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .opcode   (opcode),
      .in_valid (in_valid),
      .ack_out  (ack_out),
      .op       (op),
      .operand  (operand),
      .op_valid (op_valid),
      .ack_in   (ack_in)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: fold the offered byte stream into micro-ops by the run rules.
   function automatic logic [15:0] flush_mop(input int kind, input int delta);
      int v;
      if (kind == 1) begin
         v = ((delta % 256) + 256) % 256;
         return {v != 0, T_ADD, 12'(v)};
      end
      if (kind == 2) begin
         v = ((delta % 4096) + 4096) % 4096;
         return {v != 0, T_MOVE, 12'(v)};
      end
      return 16'd0;
   endfunction

   function automatic mop_q_t model(input byte_q_t b);
      mop_q_t      q;
      int          kind = 0;
      int          delta = 0;
      int          cnt = 0;
      logic [15:0] f;
      foreach (b[i]) begin
         int         k;
         int         s;
         logic [2:0] c;
         k = 0; s = 0; c = T_ADD;
         case (b[i])
            8'h2B: begin k = 1; s = 1;  end
            8'h2D: begin k = 1; s = -1; end
            8'h3E: begin k = 2; s = 1;  end
            8'h3C: begin k = 2; s = -1; end
            8'h5B: begin k = 3; c = T_JZ;   end
            8'h5D: begin k = 3; c = T_JNZ;  end
            8'h2E: begin k = 3; c = T_OUT;  end
            8'h2C: begin k = 3; c = T_IN;   end
            8'h00: begin k = 3; c = T_HALT; end
            default: k = 0;
         endcase
         if (k == 1 || k == 2) begin
            if (kind == k && cnt < MAX_RUN) begin
               delta += s;
               cnt++;
            end else begin
               f = flush_mop(kind, delta);
               if (f[15]) q.push_back(f[14:0]);
               kind = k; delta = s; cnt = 1;
            end
         end else if (k == 3) begin
            f = flush_mop(kind, delta);
            if (f[15]) q.push_back(f[14:0]);
            kind = 0; delta = 0; cnt = 0;
            q.push_back({c, 12'd0});
            if (c == T_HALT) break;
         end
      end
      return q;
   endfunction

   function automatic logic [7:0] rand_byte();
      int r;
      r = $urandom_range(0, 15);
      case (r)
         0, 1, 2, 3: return 8'h2B;
         4, 5:       return 8'h2D;
         6, 7:       return 8'h3E;
         8, 9:       return 8'h3C;
         10:         return 8'h5B;
         11:         return 8'h5D;
         12:         return 8'h2E;
         13:         return 8'h2C;
         14:         return 8'(8'h61 + $urandom_range(0, 25));
         default:    return 8'h0A;
      endcase
   endfunction

   // One clock: drive ack_in, sample between edges, then wait for the negedge.
   task automatic tick(output logic accepted);
      case (ack_mode)
         0:       ack_in = 1'b1;
         1:       ack_in = 1'($urandom_range(0, 1));
         default: ack_in = 1'b0;
      endcase
      #1;
      if (prev_hold) begin
         chk("hold_valid", 32'(op_valid), 32'd1);
         chk("hold_op", 32'(op), 32'(prev_op));
         chk("hold_operand", 32'(operand), 32'(prev_operand));
      end
      accepted = in_valid && ack_out;
      if (op_valid && ack_in) obs_q.push_back({op, operand});
      prev_hold    = op_valid && !ack_in;
      prev_op      = op;
      prev_operand = operand;
      @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, output int waits);
      logic acc;
      acc    = 1'b0;
      waits  = 0;
      opcode = b;
      in_valid = 1'b1;
      for (int i = 0; i < 300 && !acc; i++) begin
         tick(acc);
         if (!acc) waits++;
      end
      in_valid = 1'b0;
      sent_q.push_back(b);
      chk("accept_timeout", 32'(acc), 32'd1);
   endtask

   task automatic send_str(input string s);
      int w;
      for (int i = 0; i < s.len(); i++) send_byte(s[i], w);
   endtask

   task automatic idle(input int n);
      logic a;
      in_valid = 1'b0;
      repeat (n) tick(a);
   endtask

   task automatic expect_op(input logic [2:0] o, input logic [11:0] v);
      exp_q.push_back({o, v});
   endtask

   task automatic cmp_ops(input string tag);
      chk($sformatf("%s_count", tag), 32'(obs_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         if (i < obs_q.size())
            chk($sformatf("%s[%0d]", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
      obs_q.delete();
      exp_q.delete();
      sent_q.delete();
   endtask

   // Drops reset mid-cycle and checks outputs clear before any clock edge.
   task automatic apply_reset(input string tag);
      #2 reset = 1'b0;
      #1;
      chk({tag, "_op"}, 32'(op), 32'd0);
      chk({tag, "_operand"}, 32'(operand), 32'd0);
      chk({tag, "_op_valid"}, 32'(op_valid), 32'd0);
      chk({tag, "_ack_out"}, 32'(ack_out), 32'd0);
      @(negedge clk);
      reset     = 1'b1;
      in_valid  = 1'b0;
      prev_hold = 1'b0;
      obs_q.delete();
      exp_q.delete();
      sent_q.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int   w;
      logic a;
      string s;

      // Initial reset with a '+' offered: nothing may be acknowledged.
      opcode   = 8'h2B;
      in_valid = 1'b1;
      #3;
      chk("rst0_op", 32'(op), 32'd0);
      chk("rst0_operand", 32'(operand), 32'd0);
      chk("rst0_op_valid", 32'(op_valid), 32'd0);
      chk("rst0_ack_out", 32'(ack_out), 32'd0);
      @(negedge clk);
      reset    = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);

      // "+++." : ADD 3 then OUT, one stall cycle on '.'
      ack_mode = 0;
      send_str("+++");
      send_byte(8'h2E, w);
      chk("t1_dot_stall", 32'(w), 32'd1);
      chk("t1_lat_valid", 32'(op_valid), 32'd1);
      chk("t1_lat_op", 32'(op), 32'(T_OUT));
      idle(4);
      expect_op(T_ADD, 12'h003);
      expect_op(T_OUT, 12'h000);
      cmp_ops("t1");

      // ">><<<[" : MOVE -1 then JZ
      send_str(">><<<[");
      idle(4);
      expect_op(T_MOVE, 12'hFFF);
      expect_op(T_JZ, 12'h000);
      cmp_ops("t2");

      // "+-]" with non-command bytes interleaved: only JNZ
      s = "a+b-c\n]";
      for (int i = 0; i < s.len(); i++) begin
         send_byte(s[i], w);
         if (s[i] != "+" && s[i] != "-" && s[i] != "]")
            chk($sformatf("t3_nop_wait%0d", i), 32'(w), 32'd0);
      end
      idle(4);
      expect_op(T_JNZ, 12'h000);
      cmp_ops("t3");

      // 300 '+' then HALT: runs split at MAX_RUN, fetch blocked afterwards
      for (int i = 0; i < 300; i++) send_byte(8'h2B, w);
      send_byte(8'h00, w);
      idle(4);
      opcode   = 8'h2B;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick(a);
         chk($sformatf("t4_halt_ack%0d", i), 32'(a), 32'd0);
      end
      in_valid = 1'b0;
      expect_op(T_ADD, 12'h0FF);
      expect_op(T_ADD, 12'h02D);
      expect_op(T_HALT, 12'h000);
      cmp_ops("t4");
      apply_reset("t4_rst");

      // "+." with execute stalled: ADD 1 held, '.' not acknowledged
      ack_mode = 0;
      send_byte(8'h2B, w);
      ack_mode = 2;
      opcode   = 8'h2E;
      in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick(a);
         chk($sformatf("t5_ack_low%0d", i), 32'(a), 32'd0);
      end
      chk("t5_held_op", 32'(op), 32'(T_ADD));
      chk("t5_held_operand", 32'(operand), 32'd1);
      ack_mode = 0;
      send_byte(8'h2E, w);
      chk("t5_dot_wait", 32'(w), 32'd0);
      chk("t5_out_valid", 32'(op_valid), 32'd1);
      chk("t5_out_op", 32'(op), 32'(T_OUT));
      idle(4);
      expect_op(T_ADD, 12'h001);
      expect_op(T_OUT, 12'h000);
      cmp_ops("t5");

      // Reset mid-run with a pending run and a held output
      ack_mode = 2;
      send_str(".++");
      opcode   = 8'h2B;
      in_valid = 1'b1;
      apply_reset("t6_rst");
      ack_mode = 0;
      send_str("-.");
      idle(4);
      expect_op(T_ADD, 12'h0FF);
      expect_op(T_OUT, 12'h000);
      cmp_ops("t6");

      // Random streams with random execute back-pressure
      for (int it = 0; it < 12; it++) begin
         int n;
         ack_mode = (it % 3 == 0) ? 0 : 1;
         n = $urandom_range(10, 60);
         for (int j = 0; j < n; j++) send_byte(rand_byte(), w);
         send_byte(8'h2E, w);
         ack_mode = 0;
         idle(4);
         exp_q = model(sent_q);
         cmp_ops($sformatf("rnd%0d", it));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/stage_decode.md
Name: stage_decode

Overview:
- Decode stage directly downstream of instruction fetch: consumes fetched Brainfuck opcode bytes and emits compact micro-ops to the execute stage.
- Folds runs of '+'/'-' into one ADD and runs of '<'/'>' into one MOVE with a signed net count. Drops non-command bytes.
- Uses a valid/ack handshake on both sides. Its ack_out drives the fetch stage's ack_in.

Parameters:
- A_WIDTH, 12, data-pointer/operand width.
- D_WIDTH, 8, opcode byte and cell width.
- MAX_RUN, 255, maximum opcodes folded into one ADD/MOVE (1..255).

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  D_WIDTH  fetched opcode byte.
- in_valid  in  1  opcode is valid this cycle.
- ack_out  out  1  decode accepts opcode this cycle (to fetch ack_in).
- op  out  3  micro-op code.
- operand  out  A_WIDTH  micro-op operand.
- op_valid  out  1  op/operand valid.
- ack_in  in  1  execute consumes op this cycle.

Behaviour:
- Classes:
  - '+' (0x2B) ADD +1; '-' (0x2D) ADD -1.
  - '>' (0x3E) MOVE +1; '<' (0x3C) MOVE -1.
  - '[' JZ; ']' JNZ; '.' OUT; ',' IN.
  - 0x00 HALT.
  - Any other byte is NOP: accepted, no effect.
- Transfer rules: input transfer = in_valid && ack_out. Output transfer = op_valid && ack_in. Output slot is free when !op_valid || ack_in.
- State:
  - accumulator: cls ∈ {EMPTY, ADD, MOVE}, delta (A_WIDTH, wraps mod 2^A_WIDTH), count (8 bit).
  - output register (op, operand, op_valid).
  - halted flag.
- Per input case:
  - Same class as accumulator and count < MAX_RUN: accept; delta ±1, count+1. No output.
  - Accumulable, accumulator EMPTY: accept; load delta ±1, count 1.
  - Accumulable, different class or count == MAX_RUN: accept only if slot free. Same cycle: flush old accumulator to output, load new accumulator.
  - JZ/JNZ/OUT/IN/HALT with accumulator non-EMPTY: ack_out=0. Flush accumulator when slot free. The op is accepted in a later cycle.
  - JZ/JNZ/OUT/IN/HALT with accumulator EMPTY: accept if slot free. Op goes straight to output with operand 0.
- Flush:
  - ADD: operand = delta mod 2^D_WIDTH, zero-extended.
  - MOVE: operand = delta mod 2^A_WIDTH (two's complement).
  - If the resulting operand is 0 (e.g. "+-"), nothing is emitted, the slot is not consumed, and the accumulator goes EMPTY.
- HALT:
  - Once HALT is accepted, halted=1 and ack_out=0 until reset.
  - An already-accepted HALT still drains to the output normally.
- Latency: a non-folded op accepted in cycle N appears with op_valid=1 in cycle N+1 when the slot was free.
- Output register holds stable while op_valid && !ack_in.
- ack_out is combinational from opcode class, accumulator state, slot state, halted and reset.
- Reset (reset==0, asynchronous, mid-operation included):
  - op=0, operand=0, op_valid=0, ack_out=0.
  - Accumulator EMPTY, delta=0, count=0, halted=0.
  - Partial runs are discarded.

Decomposition:
- Package bf_pkg holds:
  - op codes: OP_ADD=0, OP_MOVE=1, OP_JZ=2, OP_JNZ=3, OP_OUT=4, OP_IN=5, OP_HALT=7;
  - class enum (NOP, ADD, MOVE, CTRL);
  - ASCII opcode constants.
- One combinational sub-module, bf_opcode_class. It maps a byte to class, step (+1/-1) and op code.

Test Plan:
- "+++" then '.', ack_in=1 → ADD 3, then OUT 0. ack_out low exactly one cycle at '.'.
- ">><<<" then '[' → MOVE 0xFFF (-1), then JZ.
- "+-" then "]" → no ADD emitted; JNZ only. "abc\n" interleaved anywhere → no output, all accepted.
- 300 '+' then 0x00, MAX_RUN=255 → ADD 255 (0xFF), ADD 45, HALT. ack_out stays 0 afterwards.
- "+." with ack_in=0 for 5 cycles → ADD 1 held stable, ack_out=0 throughout. ack_in=1 → OUT issued next.
- Assert reset low mid-run "++" with op_valid=1 → all outputs 0 asynchronously. After release, "-" → ADD 0xFF.
